// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm response sequencer: state codes, threat levels, timing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_WARN     = 3'd2,
    ST_ALARM    = 3'd3,
    ST_LOCKDOWN = 3'd4,
    ST_COOLDOWN = 3'd5
  } state_t;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_LOW  = 2'd1;
  localparam logic [1:0] LVL_HIGH = 2'd2;
  localparam logic [1:0] LVL_CRIT = 2'd3;

  localparam logic [7:0] INCIDENT_MAX = 8'hFF;

  function automatic int cycles_for(input int sec, input int rate);
    return sec * rate;
  endfunction

endpackage

// File: rtl/alarm_interval_timer.sv
// Interval timer: counts cycles since the last clear and flags when 'limit' cycles have elapsed.
// Latency: expired rises during the limit-th cycle after clear (the clearing edge starts cycle 1).
// Backpressure: none; expired stays high until the next clear.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous reset, active-low (counter to 0)
//   clear    restart the interval on this clock
//   limit    interval length in cycles (at most LIMIT)
//   expired  sticky flag, cleared only by clear/reset
module alarm_interval_timer #(
  parameter int LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [$clog2(LIMIT):0] limit,
  output logic                   expired
);

  localparam int W = $clog2(LIMIT) + 1;

  logic [W-1:0] cnt_q;

  // The count freezes once the limit is reached, which is what makes expired sticky.
  assign expired = (cnt_q >= limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      // The first cycle of the new interval already counts as one elapsed cycle.
      cnt_q <= W'(1);
    end else if (!expired) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/alarm_response_sequencer.sv
// Latching escalation FSM that turns the hazard security_level into LED, siren and door-lock drive.
// Latency: state updates one clock after its cause; physical outputs follow state by one further clock.
// Backpressure: none; all inputs are sampled every cycle and disarm pulses that cannot act are dropped.
//
// Ports:
//   clk             system clock
//   rst_n           synchronous reset, active-low
//   security_level  0 none, 1 low, 2 high, 3 critical
//   arm             armed switch (level)
//   disarm          single-cycle operator disarm pulse
//   state           current FSM state code
//   led_warn        warning LED
//   siren           siren drive
//   door_lock       lock actuator, 1 = locked
//   incident_count  incidents since reset, saturating at 255
module alarm_response_sequencer
  import alarm_pkg::*;
#(
  parameter int CLOCK_RATE    = 100_000_000,
  parameter int BLINK_HZ      = 2,
  parameter int COOLDOWN_SEC  = 5,
  parameter int LOCK_HOLD_SEC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] security_level,
  input  logic       arm,
  input  logic       disarm,
  output logic [2:0] state,
  output logic       led_warn,
  output logic       siren,
  output logic       door_lock,
  output logic [7:0] incident_count
);

  localparam int LOCK_CYC   = cycles_for(LOCK_HOLD_SEC, CLOCK_RATE);
  localparam int COOL_CYC   = cycles_for(COOLDOWN_SEC, CLOCK_RATE);
  localparam int DWELL_MAX  = (LOCK_CYC > COOL_CYC) ? LOCK_CYC : COOL_CYC;
  localparam int BLINK_HALF = CLOCK_RATE / (2 * BLINK_HZ);
  localparam int DW         = $clog2(DWELL_MAX) + 1;
  localparam int BW         = $clog2(BLINK_HALF) + 1;

  state_t          state_q;
  state_t          state_d;
  logic            state_chg;
  logic            incident_inc;
  logic            phase_q;
  logic            led_d;
  logic            siren_d;
  logic            lock_d;
  logic            dwell_exp;
  logic            blink_exp;
  logic [DW-1:0]   dwell_limit;

  assign state     = state_q;
  assign state_chg = (state_d != state_q);

  // A single dwell counter serves both timed states; its limit only changes
  // together with the state, which also restarts the count.
  assign dwell_limit = (state_q == ST_LOCKDOWN) ? DW'(LOCK_CYC) : DW'(COOL_CYC);

  alarm_interval_timer #(.LIMIT(DWELL_MAX)) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_chg),
    .limit   (dwell_limit),
    .expired (dwell_exp)
  );

  // Free-running half-period timer: restarts on state entry and on each expiry.
  alarm_interval_timer #(.LIMIT(BLINK_HALF)) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_chg | blink_exp),
    .limit   (BW'(BLINK_HALF)),
    .expired (blink_exp)
  );

  // Next state, incident pulse and output drive for the current state.
  // Priority within each state: arm=0 > higher level > disarm.
  always_comb begin
    state_d      = state_q;
    incident_inc = 1'b0;
    led_d        = 1'b0;
    siren_d      = 1'b0;
    lock_d       = 1'b0;
    case (state_q)
      ST_DISARMED: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_DISARMED;
        end else begin
          case (security_level)
            LVL_LOW:  state_d = ST_WARN;
            LVL_HIGH: state_d = ST_ALARM;
            LVL_CRIT: state_d = ST_LOCKDOWN;
            default:  state_d = ST_ARMED;
          endcase
          incident_inc = (security_level != LVL_NONE);
        end
      end
      ST_WARN: begin
        led_d = phase_q;
        if (!arm)                             state_d = ST_DISARMED;
        else if (security_level == LVL_CRIT)  state_d = ST_LOCKDOWN;
        else if (security_level == LVL_HIGH)  state_d = ST_ALARM;
        else if (disarm)                      state_d = ST_COOLDOWN;
      end
      ST_ALARM: begin
        led_d   = 1'b1;
        siren_d = phase_q;
        if (!arm)                             state_d = ST_DISARMED;
        else if (security_level == LVL_CRIT)  state_d = ST_LOCKDOWN;
        else if (disarm)                      state_d = ST_COOLDOWN;
      end
      ST_LOCKDOWN: begin
        led_d   = 1'b1;
        siren_d = 1'b1;
        lock_d  = 1'b1;
        // arm and level are deliberately ignored; an early disarm is simply lost.
        if (disarm && dwell_exp) state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (!arm)           state_d = ST_DISARMED;
        else if (dwell_exp) state_d = ST_ARMED;
      end
      default: begin
        state_d = ST_DISARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_DISARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q        <= 1'b1;
      led_warn       <= 1'b0;
      siren          <= 1'b0;
      door_lock      <= 1'b0;
      incident_count <= '0;
    end else begin
      if (state_chg) begin
        phase_q <= 1'b1;
      end else if (blink_exp) begin
        phase_q <= ~phase_q;
      end
      led_warn  <= led_d;
      siren     <= siren_d;
      door_lock <= lock_d;
      if (incident_inc && (incident_count != INCIDENT_MAX)) begin
        incident_count <= incident_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alarm_response_sequencer.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_alarm_response_sequencer;

  localparam int CLOCK_RATE    = 20;
  localparam int BLINK_HZ      = 2;
  localparam int COOLDOWN_SEC  = 2;
  localparam int LOCK_HOLD_SEC = 3;

  localparam int HALF     = CLOCK_RATE / (2 * BLINK_HZ);   // 5
  localparam int COOL_CYC = COOLDOWN_SEC * CLOCK_RATE;     // 40
  localparam int LOCK_CYC = LOCK_HOLD_SEC * CLOCK_RATE;    // 60

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] security_level;
  logic       arm;
  logic       disarm;
  logic [2:0] state;
  logic       led_warn;
  logic       siren;
  logic       door_lock;
  logic [7:0] incident_count;

  alarm_response_sequencer #(
    .CLOCK_RATE    (CLOCK_RATE),
    .BLINK_HZ      (BLINK_HZ),
    .COOLDOWN_SEC  (COOLDOWN_SEC),
    .LOCK_HOLD_SEC (LOCK_HOLD_SEC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .security_level (security_level),
    .arm            (arm),
    .disarm         (disarm),
    .state          (state),
    .led_warn       (led_warn),
    .siren          (siren),
    .door_lock      (door_lock),
    .incident_count (incident_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       led;
    logic       sir;
    logic       lck;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: state number, cycles already spent in it, incidents so far.
  int m_st  = 0;
  int m_age = 0;
  int m_cnt = 0;

  task automatic model_and_push(input logic r, input logic a, input logic d, input logic [1:0] l);
    obs_t e;
    int   nst;
    int   tgt;
    logic ph;
    e  = '0;
    // Blink phase: high for the first HALF cycles in a state, then alternating.
    ph = ((m_age / HALF) % 2) == 0;
    if (m_st == 2) begin
      e.led = ph;
    end else if (m_st == 3) begin
      e.led = 1'b1;
      e.sir = ph;
    end else if (m_st == 4) begin
      e.led = 1'b1;
      e.sir = 1'b1;
      e.lck = 1'b1;
    end
    nst = m_st;
    tgt = int'(l) + 1;   // level N escalates to state N+1
    if (!r) begin
      nst   = 0;
      m_cnt = 0;
      e.led = 1'b0;
      e.sir = 1'b0;
      e.lck = 1'b0;
    end else if (m_st == 4) begin
      if (d && (m_age + 1 >= LOCK_CYC)) nst = 5;
    end else if (!a) begin
      nst = 0;
    end else if (m_st == 0) begin
      nst = 1;
    end else if (m_st == 5) begin
      if (m_age + 1 >= COOL_CYC) nst = 1;
    end else if (m_st >= 1 && m_st <= 3) begin
      if (l != 2'd0 && tgt > m_st) begin
        nst = tgt;
        if (m_st == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
      end else if (d && m_st != 1) begin
        nst = 5;
      end
    end else begin
      nst = 0;
    end
    m_age = (nst != m_st || !r) ? 0 : m_age + 1;
    m_st  = nst;
    e.st  = 3'(nst);
    e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic a, input logic d, input logic [1:0] l);
    @(negedge clk);
    rst_n          = r;
    arm            = a;
    disarm         = d;
    security_level = l;
    model_and_push(r, a, d, l);
  endtask

  // Hold inputs until the model's current state has spent n cycles (bounded).
  task automatic run_to_age(input int n, input logic a, input logic [1:0] l);
    for (int i = 0; i < 200 && m_age < n; i++) step(1'b1, a, 1'b0, l);
  endtask

  // Monitor
  initial begin : monitor
    obs_t e;
    obs_t g;
    int   cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {state, led_warn, siren, door_lock, incident_count};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL cycle_%0d: got st=%0d led=%b sir=%b lck=%b cnt=%0d, want st=%0d led=%b sir=%b lck=%b cnt=%0d",
                   cyc, g.st, g.led, g.sir, g.lck, g.cnt, e.st, e.led, e.sir, e.lck, e.cnt);
        end
        cyc++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no end of stimulus, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic       r;
    logic       a;
    logic       d;
    logic [1:0] l;
    rst_n = 1'b0; arm = 1'b0; disarm = 1'b0; security_level = 2'd0;

    // Reset with arm and critical level present, then straight into LOCKDOWN.
    repeat (3) step(1'b0, 1'b1, 1'b0, 2'd3);
    step(1'b1, 1'b1, 1'b0, 2'd3);
    step(1'b1, 1'b1, 1'b0, 2'd3);

    // LOCKDOWN: early disarm (30th cycle) and arm=0 ignored, 59th-cycle disarm dropped, 60th accepted.
    run_to_age(29, 1'b0, 2'd3);
    step(1'b1, 1'b0, 1'b1, 2'd3);
    run_to_age(58, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);

    // COOLDOWN with critical level held: 40 cycles, ARMED, LOCKDOWN again.
    repeat (45) step(1'b1, 1'b1, 1'b0, 2'd3);
    run_to_age(59, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    repeat (42) step(1'b1, 1'b1, 1'b0, 2'd0);

    // WARN blinking, latching on level 0, escalation beating disarm, ALARM siren blink.
    repeat (12) step(1'b1, 1'b1, 1'b0, 2'd1);
    repeat (6)  step(1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd2);
    repeat (14) step(1'b1, 1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    repeat (42) step(1'b1, 1'b1, 1'b0, 2'd0);

    // arm=0 beats escalation from WARN.
    step(1'b1, 1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b0, 1'b0, 2'd3);
    step(1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0);

    // 300 incidents to drive the counter into saturation.
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 1'b1, 1'b0, 2'd1);
      step(1'b1, 1'b1, 1'b1, 2'd0);
      repeat (40) step(1'b1, 1'b1, 1'b0, 2'd0);
    end
    step(1'b1, 1'b1, 1'b0, 2'd0);

    // Reset in the middle of LOCKDOWN, then a fresh hold period.
    step(1'b1, 1'b1, 1'b0, 2'd3);
    run_to_age(17, 1'b1, 2'd0);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'd3);
    run_to_age(58, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 2'd0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 199) != 0);
      a = ($urandom_range(0, 19) != 0);
      d = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      step(r, a, d, l);
    end
    step(1'b1, 1'b1, 1'b0, 2'd0);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
